// File: rtl/spi_px_master.sv
// spi_px_master: mode-0 SPI host that shifts a pixel word out on SDI and captures SDO
module spi_px_master #(
  parameter int PX_BITS    = 24,
  parameter int HALF_DIV   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [PX_BITS-1:0] tx_data_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic [PX_BITS-1:0] rx_data_o,
  output logic               rx_valid_o,
  output logic               busy_o,
  output logic               spi_cs_o,
  output logic               spi_sck_o,
  output logic               spi_sdi_o,
  input  logic               spi_sdo_i
);
  localparam int BW = $clog2(PX_BITS + 1);
  localparam logic [7:0] DIV_END = 8'(HALF_DIV - 1);
  localparam logic [7:0] GAP_END = 8'(GAP_CYCLES - 2);
  localparam logic [BW-1:0] BIT_END = BW'(PX_BITS);
  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, DONE, GAP} state_t;
  state_t             state_q;
  logic [PX_BITS-2:0] tx_shift_q;
  logic [PX_BITS-1:0] rx_shift_q, rx_data_q;
  logic [BW-1:0]      bit_q;
  logic [7:0]         div_q;
  logic               tx_ready_q, rx_valid_q, cs_q, sck_q, sdi_q;
  logic               div_end;
  assign div_end    = div_q == DIV_END;
  assign tx_ready_o = tx_ready_q;
  assign busy_o     = ~tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_cs_o   = cs_q;
  assign spi_sck_o  = sck_q;
  assign spi_sdi_o  = sdi_q;
  // Catch out-of-range divider or gap settings in simulation
  always_ff @(posedge clk_i)
    assert (HALF_DIV >= 4 && HALF_DIV <= 255 && GAP_CYCLES >= 1 && GAP_CYCLES <= 255);
  // Transaction sequencer: SCK phases are timed by div_q, bits counted by bit_q
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (tx_valid_i) begin
          state_q    <= SETUP;
          tx_shift_q <= tx_data_i[PX_BITS-2:0];
          sdi_q      <= tx_data_i[PX_BITS-1];
          bit_q      <= '0;
          div_q      <= '0;
          cs_q       <= 1'b0;
          tx_ready_q <= 1'b0;
        end
        SETUP, SCK_LO: begin
          div_q <= div_end ? '0 : div_q + 8'd1;
          if (div_end) begin
            if (state_q == SCK_LO && bit_q == BIT_END) begin
              state_q    <= DONE;
              cs_q       <= 1'b1;
              sdi_q      <= 1'b0;
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              state_q    <= SCK_HI;
              sck_q      <= 1'b1;
              rx_shift_q <= {rx_shift_q[PX_BITS-2:0], spi_sdo_i};
            end
          end
        end
        SCK_HI: begin
          div_q <= div_end ? '0 : div_q + 8'd1;
          if (div_end) begin
            state_q <= SCK_LO;
            sck_q   <= 1'b0;
            bit_q   <= bit_q + 1'b1;
            if (bit_q + 1'b1 < BIT_END) begin
              sdi_q      <= tx_shift_q[PX_BITS-2];
              tx_shift_q <= tx_shift_q << 1;
            end
          end
        end
        DONE: begin
          div_q      <= '0;
          state_q    <= (GAP_CYCLES > 1) ? GAP : IDLE;
          tx_ready_q <= GAP_CYCLES == 1;
        end
        GAP: begin
          div_q <= div_q + 8'd1;
          if (div_q == GAP_END) begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
